cmos_ioctl_bridge: RTL and testbench
====================================

Name: cmos_ioctl_bridge

Overview:
- Bridges the HPS ioctl channel and the 1024x4 Williams CMOS NVRAM in williams2.
- Upload direction (core -> HPS, save): answers ioctl_rd requests by reading two nibbles from the NVRAM and packing them into one byte.
- Download direction (HPS -> core, restore): unpacks each ioctl_wr byte into two nibble writes.
- Owns port B of the dual-port CMOS RAM; the game CPU keeps port A.

Parameters:
NIB_AW, 10, nibble address width of the CMOS RAM; image size is 2**(NIB_AW-1) bytes (512 by default).
RD_LAT, 1, read latency in clocks of RAM port B (1 or 2 supported).

Ports:
clk_sys  in  1  system clock (12 MHz domain); all logic rising-edge.
reset  in  1  synchronous, active-high reset.
nv_sel  in  1  high when ioctl_index selects the NVRAM image; gates all ioctl activity.
ioctl_upload  in  1  HPS upload session active.
ioctl_download  in  1  HPS download session active.
ioctl_rd  in  1  one-cycle read request strobe.
ioctl_wr  in  1  one-cycle write strobe.
ioctl_addr  in  25  byte address of the current request.
ioctl_dout  in  8  write byte from HPS.
ioctl_din  out  8  read byte to HPS.
ram_addr  out  NIB_AW  port B nibble address.
ram_we  out  1  port B write enable.
ram_wdata  out  4  port B write nibble.
ram_rdata  in  4  port B read nibble.
busy  out  1  high while an access is in progress.

Behaviour:
- Reset values: ioctl_din=8'hFF, ram_addr=0, ram_we=0, ram_wdata=0, busy=0. FSM goes to IDLE. Reset abandons any in-flight access, and ram_we is low in the cycle after reset is sampled.
- A request is accepted only in IDLE. An ioctl_rd requires nv_sel & ioctl_upload; an ioctl_wr requires nv_sel & ioctl_download.
- A request that arrives while busy=1 is dropped. No queueing.
- If ioctl_rd and ioctl_wr arrive in the same cycle, the write wins.
- Range rule: a byte address is in range when ioctl_addr < 2**(NIB_AW-1).
- Out-of-range read: ioctl_din=8'hFF on the next cycle, no RAM access, busy stays 0.
- Out-of-range write: ignored entirely.
- FSM states: IDLE, RD_LO, RD_LO_W, RD_HI, RD_HI_W, DONE, WR_LO, WR_HI.
- Read sequence:
  - IDLE -> RD_LO: ram_addr={addr[NIB_AW-2:0],1'b0}, busy=1.
  - Wait RD_LAT cycles, then capture ram_rdata as lo.
  - RD_HI: ram_addr={addr,1'b1}. Wait RD_LAT cycles, then capture hi.
  - DONE: ioctl_din={hi,lo}, busy=0, return to IDLE.
  - Total latency from the rd strobe to a valid ioctl_din is 2*RD_LAT+3 clocks, i.e. 5 clocks at RD_LAT=1.
- ioctl_din holds its value until the next completed read or reset. The HPS spaces rd strobes at least 8 clocks apart.
- Write sequence:
  - ioctl_dout is latched on accept.
  - WR_LO: ram_addr={addr,0}, ram_wdata=dout[3:0], ram_we=1.
  - WR_HI: ram_addr={addr,1}, ram_wdata=dout[7:4], ram_we=1.
  - Return to IDLE; ram_we=0. busy is high for exactly 2 cycles.
- Packing is little-nibble-first: even nibble address = byte[3:0].
- ram_we is never asserted outside WR_LO/WR_HI.
- A session end (upload/download falling) mid-sequence does not abort; the sequence completes normally.
- Address wrap: only ioctl_addr[NIB_AW-2:0] is used after the range check.

Optional Feature:
NVRAM_DIRTY_EN:
- Defined: adds inputs game_we (1) and nv_load_done (1), and output nv_dirty (1).
- nv_dirty resets to 0. It is set on any game_we pulse after nv_load_done has been seen, and cleared when an upload session ends (ioctl_upload falling) after at least one completed read.
- If a game_we arrives in the same cycle as the clear, set wins.
- Undefined: none of these ports exist and there is no added logic.

Test Plan:
- Download bytes 0x21 at addr 0 and 0xA5 at addr 3 -> nibble writes 0:1, 1:2, 6:5, 7:A; ram_we high 2 cycles per byte; busy=2 cycles each.
- Preload RAM[6]=5, RAM[7]=A; ioctl_rd at addr 3 -> ioctl_din=8'hA5 exactly 5 clocks after the strobe (RD_LAT=1); 7 clocks with RD_LAT=2.
- Read at addr 512 -> ioctl_din=8'hFF the next cycle, no ram_addr change, busy=0. Write at addr 600 -> no ram_we.
- Second ioctl_rd 2 cycles after the first -> dropped; the first result is still correct; only one read sequence occurs.
- Assert reset during WR_LO -> ram_we=0 the cycle after, FSM in IDLE, ioctl_din=8'hFF; a following write completes normally.
- NVRAM_DIRTY_EN: nv_load_done, then game_we -> nv_dirty=1; upload 512 bytes then drop ioctl_upload -> nv_dirty=0; game_we on the same cycle as the drop -> nv_dirty stays 1.

Source files
------------

// File: rtl/cmos_ioctl_bridge.sv
// cmos_ioctl_bridge
// Connects the HPS ioctl channel to port B of the 1024x4 Williams CMOS NVRAM.
// On upload (save), each ioctl_rd returns one byte packed from two nibbles.
// On download (restore), each ioctl_wr byte is split into two nibble writes.
// Nibble order is little-nibble-first: even nibble address holds byte[3:0].
//
// Optional build macro: NVRAM_DIRTY_EN adds game_we / nv_load_done inputs and
// an nv_dirty output that tracks whether the game has modified the NVRAM
// since the last completed save.
module cmos_ioctl_bridge #(
    parameter int NIB_AW = 10,  // nibble address width; image is 2**(NIB_AW-1) bytes
    parameter int RD_LAT = 1    // port B read latency in clocks (1 or 2)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              nv_sel,
    input  logic              ioctl_upload,
    input  logic              ioctl_download,
    input  logic              ioctl_rd,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic [NIB_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [3:0]        ram_wdata,
    input  logic [3:0]        ram_rdata,
`ifdef NVRAM_DIRTY_EN
    input  logic              game_we,
    input  logic              nv_load_done,
    output logic              nv_dirty,
`endif
    output logic              busy
);

    // Byte address width of the image.
    localparam int BYTE_AW = NIB_AW - 1;

    // Last count of a read wait state; the captured nibble is valid then.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_LO_W,
        RD_HI,
        RD_HI_W,
        DONE,
        WR_LO,
        WR_HI
    } state_t;

    state_t               state_q, state_d;
    logic [BYTE_AW-1:0]   byte_addr_q, byte_addr_d;  // byte address of the access in flight
    logic [3:0]           wr_hi_q, wr_hi_d;          // upper nibble of the byte being restored
    logic [3:0]           lo_nib_q, lo_nib_d;        // lower nibble captured during a save read
    logic [1:0]           wait_cnt_q, wait_cnt_d;    // RAM read latency counter

    logic [7:0]           din_d;
    logic [NIB_AW-1:0]    ram_addr_d;
    logic                 ram_we_d;
    logic [3:0]           ram_wdata_d;
    logic                 busy_d;

    logic                 rd_req;
    logic                 wr_req;
    logic                 addr_in_range;

    // A request only counts when the NVRAM image is selected and the
    // matching session direction is active.
    assign rd_req        = ioctl_rd & nv_sel & ioctl_upload;
    assign wr_req        = ioctl_wr & nv_sel & ioctl_download;
    assign addr_in_range = (ioctl_addr[24:BYTE_AW] == '0);

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the case statement can infer a latch.
        state_d     = state_q;
        byte_addr_d = byte_addr_q;
        wr_hi_d     = wr_hi_q;
        lo_nib_d    = lo_nib_q;
        wait_cnt_d  = wait_cnt_q;
        din_d       = ioctl_din;
        ram_addr_d  = ram_addr;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata;
        busy_d      = busy;

        case (state_q)
            IDLE: begin
                // Write has priority over a simultaneous read strobe.
                if (wr_req) begin
                    if (addr_in_range) begin
                        byte_addr_d = ioctl_addr[BYTE_AW-1:0];
                        wr_hi_d     = ioctl_dout[7:4];
                        ram_addr_d  = {ioctl_addr[BYTE_AW-1:0], 1'b0};
                        ram_wdata_d = ioctl_dout[3:0];
                        ram_we_d    = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = WR_LO;
                    end
                end else if (rd_req) begin
                    if (addr_in_range) begin
                        byte_addr_d = ioctl_addr[BYTE_AW-1:0];
                        ram_addr_d  = {ioctl_addr[BYTE_AW-1:0], 1'b0};
                        busy_d      = 1'b1;
                        state_d     = RD_LO;
                    end else begin
                        // Beyond the image: answer with erased-flash data.
                        din_d = 8'hFF;
                    end
                end
            end

            RD_LO: begin
                wait_cnt_d = '0;
                state_d    = RD_LO_W;
            end

            RD_LO_W: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    lo_nib_d   = ram_rdata;
                    ram_addr_d = {byte_addr_q, 1'b1};
                    state_d    = RD_HI;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end

            RD_HI: begin
                wait_cnt_d = '0;
                state_d    = RD_HI_W;
            end

            RD_HI_W: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    din_d   = {ram_rdata, lo_nib_q};
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            WR_LO: begin
                ram_addr_d  = {byte_addr_q, 1'b1};
                ram_wdata_d = wr_hi_q;
                ram_we_d    = 1'b1;
                state_d     = WR_HI;
            end

            WR_HI: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output update; reset abandons any access in flight.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state_q     <= IDLE;
            byte_addr_q <= '0;
            wr_hi_q     <= '0;
            lo_nib_q    <= '0;
            wait_cnt_q  <= '0;
            ioctl_din   <= 8'hFF;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_addr_q <= byte_addr_d;
            wr_hi_q     <= wr_hi_d;
            lo_nib_q    <= lo_nib_d;
            wait_cnt_q  <= wait_cnt_d;
            ioctl_din   <= din_d;
            ram_addr    <= ram_addr_d;
            ram_we      <= ram_we_d;
            ram_wdata   <= ram_wdata_d;
            busy        <= busy_d;
        end
    end

`ifdef NVRAM_DIRTY_EN
    logic load_seen_q;  // initial NVRAM restore has finished
    logic rd_seen_q;    // at least one save read completed in this upload session
    logic upload_q;     // previous ioctl_upload, for falling-edge detection
    logic upload_fall;
    logic dirty_set;
    logic dirty_clr;

    assign upload_fall = upload_q & ~ioctl_upload;
    assign dirty_set   = game_we & load_seen_q;
    // A read finishing in the very cycle the session ends still counts.
    assign dirty_clr   = upload_fall & (rd_seen_q | (state_q == DONE));

    // Dirty tracking: game writes mark the image dirty, a completed save clears it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            load_seen_q <= 1'b0;
            rd_seen_q   <= 1'b0;
            upload_q    <= 1'b0;
            nv_dirty    <= 1'b0;
        end else begin
            upload_q <= ioctl_upload;
            if (nv_load_done) begin
                load_seen_q <= 1'b1;
            end
            if (upload_fall) begin
                rd_seen_q <= 1'b0;
            end else if (state_q == DONE) begin
                rd_seen_q <= 1'b1;
            end
            // A game write in the same cycle as the clear keeps the image dirty.
            if (dirty_set) begin
                nv_dirty <= 1'b1;
            end else if (dirty_clr) begin
                nv_dirty <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cmos_ioctl_bridge.sv
// Testbench for cmos_ioctl_bridge: a behavioural 1024x4 port-B RAM plus
// table-driven ioctl transactions and hand-written multi-cycle sequences.
// Build with NVRAM_DIRTY_EN defined to also exercise the dirty tracker.
module tb_cmos_ioctl_bridge;

    localparam int NIB_AW = 10;
    localparam int RD_LAT = 1;
    localparam int RD_BUSY = 2 * RD_LAT + 2;  // busy cycles of one read
    localparam int RD_TOTAL = 2 * RD_LAT + 3; // strobe-to-data latency

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        nv_sel;
    logic        ioctl_upload;
    logic        ioctl_download;
    logic        ioctl_rd;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic [NIB_AW-1:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_wdata;
    logic [3:0]  ram_rdata;
    logic        busy;
`ifdef NVRAM_DIRTY_EN
    logic        game_we;
    logic        nv_load_done;
    logic        nv_dirty;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    cmos_ioctl_bridge #(
        .NIB_AW(NIB_AW),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .nv_sel         (nv_sel),
        .ioctl_upload   (ioctl_upload),
        .ioctl_download (ioctl_download),
        .ioctl_rd       (ioctl_rd),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_din      (ioctl_din),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
`ifdef NVRAM_DIRTY_EN
        .game_we        (game_we),
        .nv_load_done   (nv_load_done),
        .nv_dirty       (nv_dirty),
`endif
        .busy           (busy)
    );

    // Port-B RAM model with RD_LAT clocks of read latency.
    logic [3:0] mem [0:(1<<NIB_AW)-1];
    logic [3:0] rpipe [RD_LAT];

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rpipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata = rpipe[RD_LAT-1];

    typedef struct {
        logic        wr;
        logic        rd;
        logic        sel;
        logic        up;
        logic        dn;
        logic [24:0] addr;
        logic [7:0]  dout;
        int          exp_busy;
        int          exp_we;
        logic [7:0]  exp_din;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Applies one strobe and counts busy / ram_we cycles over a fixed window.
    task automatic run_vec(input vec_t v, output int nbusy, output int nwe);
        nv_sel         = v.sel;
        ioctl_upload   = v.up;
        ioctl_download = v.dn;
        ioctl_wr       = v.wr;
        ioctl_rd       = v.rd;
        ioctl_addr     = v.addr;
        ioctl_dout     = v.dout;
        tick();
        ioctl_wr = 1'b0;
        ioctl_rd = 1'b0;
        nbusy = 0;
        nwe = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy) nbusy++;
            if (ram_we) nwe++;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int nw;
        logic [9:0] idx;

        reset = 1'b1;
        nv_sel = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_download = 1'b0;
        ioctl_rd = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
`ifdef NVRAM_DIRTY_EN
        game_we = 1'b0;
        nv_load_done = 1'b0;
`endif
        tick();
        tick();

        // Reset values.
        check("rst_din", ioctl_din, 8'hFF);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_busy", busy, 0);
`ifdef NVRAM_DIRTY_EN
        check("rst_nv_dirty", nv_dirty, 0);
`endif
        reset = 1'b0;
        tick();

        //           wr    rd    sel   up    dn    addr     dout   busy     we  din
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 25'd0,   8'h21, 2,       2, 8'hFF};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 25'd3,   8'hA5, 2,       2, 8'hFF};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 25'd2,   8'h00, 2,       2, 8'hFF};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 25'd3,   8'h00, RD_BUSY, 0, 8'hA5};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 25'd0,   8'h00, RD_BUSY, 0, 8'h21};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 25'd512, 8'h00, 0,       0, 8'hFF};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 25'd600, 8'h55, 0,       0, 8'hFF};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 25'd511, 8'h3C, 2,       2, 8'hFF};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 25'd511, 8'h00, RD_BUSY, 0, 8'h3C};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 25'd3,   8'h00, 0,       0, 8'h3C};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 25'd0,   8'hFF, 0,       0, 8'h3C};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 25'd0,   8'h00, RD_BUSY, 0, 8'h21};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 25'd5,   8'h96, 2,       2, 8'h21};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 25'd5,   8'h00, RD_BUSY, 0, 8'h96};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 25'd3,   8'h00, 0,       0, 8'h96};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 25'd1,   8'h77, 0,       0, 8'h96};

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], nb, nw);
            check($sformatf("vec%0d_busy_cycles", i), nb, vecs[i].exp_busy);
            check($sformatf("vec%0d_we_cycles", i), nw, vecs[i].exp_we);
            check($sformatf("vec%0d_din", i), ioctl_din, vecs[i].exp_din);
            if (vecs[i].exp_we == 2) begin
                idx = {vecs[i].addr[8:0], 1'b0};
                check($sformatf("vec%0d_mem_lo", i), mem[idx], vecs[i].dout[3:0]);
                idx = {vecs[i].addr[8:0], 1'b1};
                check($sformatf("vec%0d_mem_hi", i), mem[idx], vecs[i].dout[7:4]);
            end
        end

        // Nibble placement of the first two restored bytes.
        check("nib0", mem[0], 4'h1);
        check("nib1", mem[1], 4'h2);
        check("nib6", mem[6], 4'h5);
        check("nib7", mem[7], 4'hA);

        // Exact read latency: old data one clock before, new data on time.
        nv_sel = 1'b1;
        ioctl_upload = 1'b1;
        ioctl_download = 1'b0;
        ioctl_rd = 1'b1;
        ioctl_addr = 25'd3;
        for (int k = 1; k <= RD_TOTAL; k++) begin
            tick();
            if (k == 1) ioctl_rd = 1'b0;
            if (k == RD_TOTAL - 1) check("lat_before", ioctl_din, 8'h96);
            if (k == RD_TOTAL) check("lat_on_time", ioctl_din, 8'hA5);
        end
        repeat (4) tick();

        // Out-of-range read: FF next cycle, port B untouched, never busy.
        ioctl_rd = 1'b1;
        ioctl_addr = 25'd512;
        tick();
        ioctl_rd = 1'b0;
        check("oor_din", ioctl_din, 8'hFF);
        check("oor_busy", busy, 0);
        check("oor_ram_addr", ram_addr, 10'd7);
        tick();
        check("oor_ram_addr_hold", ram_addr, 10'd7);
        check("oor_busy_hold", busy, 0);
        repeat (3) tick();

        // Second strobe two cycles into a read is dropped.
        nb = 0;
        ioctl_rd = 1'b1;
        ioctl_addr = 25'd0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (busy) nb++;
            if (k == 1) ioctl_rd = 1'b0;
            if (k == 2) begin
                ioctl_rd = 1'b1;
                ioctl_addr = 25'd3;
            end
            if (k == 3) ioctl_rd = 1'b0;
        end
        check("drop_busy_cycles", nb, RD_BUSY);
        check("drop_din", ioctl_din, 8'h21);

        // Reset during WR_LO abandons the write.
        ioctl_upload = 1'b0;
        ioctl_download = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_addr = 25'd2;
        ioctl_dout = 8'h7E;
        tick();
        ioctl_wr = 1'b0;
        check("rstwr_we_in_wr_lo", ram_we, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstwr_we", ram_we, 0);
        check("rstwr_busy", busy, 0);
        check("rstwr_din", ioctl_din, 8'hFF);
        check("rstwr_ram_addr", ram_addr, 0);
        tick();
        check("rstwr_we_after", ram_we, 0);
        check("rstwr_hi_untouched", mem[5], 4'h0);
        run_vec('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 25'd2, 8'h7E, 2, 2, 8'hFF}, nb, nw);
        check("rstwr_retry_busy", nb, 2);
        check("rstwr_retry_we", nw, 2);
        check("rstwr_retry_lo", mem[4], 4'hE);
        check("rstwr_retry_hi", mem[5], 4'h7);
        run_vec('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 25'd2, 8'h00, RD_BUSY, 0, 8'h7E}, nb, nw);
        check("rstwr_readback", ioctl_din, 8'h7E);

`ifdef NVRAM_DIRTY_EN
        // Game write before the initial load is complete does not mark dirty.
        ioctl_upload = 1'b0;
        ioctl_download = 1'b0;
        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        tick();
        check("dirty_before_load", nv_dirty, 0);
        nv_load_done = 1'b1;
        tick();
        nv_load_done = 1'b0;
        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        tick();
        check("dirty_set", nv_dirty, 1);

        // Full 512-byte save then session end clears it.
        ioctl_upload = 1'b1;
        tick();
        for (int a = 0; a < 512; a++) begin
            ioctl_rd = 1'b1;
            ioctl_addr = 25'(a);
            tick();
            ioctl_rd = 1'b0;
            repeat (7) tick();
        end
        check("dirty_during_save", nv_dirty, 1);
        ioctl_upload = 1'b0;
        tick();
        check("dirty_cleared", nv_dirty, 0);

        // Game write in the same cycle as the session end keeps it dirty.
        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        check("dirty_reset_by_game", nv_dirty, 1);
        ioctl_upload = 1'b1;
        ioctl_rd = 1'b1;
        ioctl_addr = 25'd0;
        tick();
        ioctl_rd = 1'b0;
        repeat (8) tick();
        ioctl_upload = 1'b0;
        game_we = 1'b1;
        tick();
        game_we = 1'b0;
        check("dirty_set_wins", nv_dirty, 1);
        tick();
        check("dirty_set_wins_hold", nv_dirty, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
